an_sec_serial_decoder: RTL



---
 rtl/an_sec_pkg.sv | 25 ++
 rtl/an_mod_double.sv | 16 +
 rtl/an_sec_serial_decoder.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/an_sec_pkg.sv
// Shared types and constants for the bit-serial AN-code single-error decoder.
// Default geometry: 20 data bits, A = 6311, 13-bit residue.
package an_sec_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REDUCE = 2'd1,
    SEARCH = 2'd2,
    DONE   = 2'd3
  } an_state_t;

  localparam int AN_DATA_W = 20;
  localparam int AN_A      = 6311;
  localparam int AN_R_W    = 13;

  // (2x + b) mod m, valid while x < m, so that a single conditional subtract suffices.
  function automatic logic [31:0] mod_dbl(input logic [31:0] x, input logic b,
                                          input logic [31:0] m);
    logic [32:0] t;
    t = {x, 1'b0} + 33'(b);
    if (t >= {1'b0, m}) t = t - {1'b0, m};
    return t[31:0];
  endfunction

endpackage

// File: rtl/an_mod_double.sv
// Modular doubler y = (2x + b) mod A. One instance serves both the residue
// reduction and the +/-2^i search.
module an_mod_double
  import an_sec_pkg::*;
#(
  parameter int A   = AN_A,
  parameter int R_W = AN_R_W
) (
  input  logic [R_W-1:0] x,
  input  logic           b,
  output logic [R_W-1:0] y
);

  assign y = R_W'(mod_dbl(32'(x), b, 32'(A)));

endmodule

// File: rtl/an_sec_serial_decoder.sv
// Sequential AN-code single-error-correcting decoder: bit-serial residue, then a search over +/-2^i mod A.
// Optional macro AN_SEC_UNCORR_EN adds the out_uncorr flag for nonzero residue with no match.
module an_sec_serial_decoder
  import an_sec_pkg::*;
#(
  parameter int DATA_W = AN_DATA_W,
  parameter int A      = AN_A,
  parameter int R_W    = AN_R_W,
  parameter int CODE_W = DATA_W + R_W,
  parameter int LOC_W  = 7
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [CODE_W-1:0]       in_cw,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CODE_W-1:0]       out_cw,
  output logic signed [LOC_W-1:0] out_loc,
  output logic                    out_err
`ifdef AN_SEC_UNCORR_EN
  ,
  output logic                    out_uncorr
`endif
);

  localparam int CNT_W = $clog2(CODE_W);

  an_state_t                state, state_nxt;
  logic [CODE_W-1:0]        cw;
  logic [R_W-1:0]           r, p, neg_r, md_x, md_y;
  logic                     md_b;
  logic [CNT_W-1:0]         cnt;
  logic                     hit_pos, hit_neg, cnt_last, cnt_zero;
  logic signed [LOC_W-1:0]  loc_mag;
  logic [CODE_W-1:0]        bit_i;

  // The doubler reduces r during REDUCE and advances p during SEARCH.
  assign md_x = (state == SEARCH) ? p : r;
  assign md_b = (state == REDUCE) ? cw[cnt] : 1'b0;

  an_mod_double #(.A(A), .R_W(R_W)) u_mod_double (
    .x (md_x),
    .b (md_b),
    .y (md_y)
  );

  assign neg_r    = R_W'(A) - r;
  assign hit_pos  = (p == r);
  assign hit_neg  = (p == neg_r);
  assign cnt_last = (cnt == CNT_W'(CODE_W - 1));
  assign cnt_zero = (cnt == '0);
  assign loc_mag  = signed'(LOC_W'(cnt) + LOC_W'(1));
  assign bit_i    = CODE_W'(1) << cnt;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (in_valid) state_nxt = REDUCE;
      REDUCE: if (cnt_zero) state_nxt = (md_y == '0) ? DONE : SEARCH;
      SEARCH: if (hit_pos || hit_neg || cnt_last) state_nxt = DONE;
      DONE:   if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cw      <= '0;
      r       <= '0;
      p       <= '0;
      cnt     <= '0;
      out_cw  <= '0;
      out_loc <= '0;
      out_err <= 1'b0;
`ifdef AN_SEC_UNCORR_EN
      out_uncorr <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          cw  <= in_cw;
          r   <= '0;
          cnt <= CNT_W'(CODE_W - 1);
        end
        REDUCE: begin
          r <= md_y;
          if (cnt_zero) begin
            if (md_y == '0) begin
              out_cw  <= cw;
              out_loc <= '0;
              out_err <= 1'b0;
`ifdef AN_SEC_UNCORR_EN
              out_uncorr <= 1'b0;
`endif
            end else begin
              p   <= R_W'(1);
              cnt <= '0;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        SEARCH: begin
          if (hit_pos || hit_neg || cnt_last) begin
            out_err <= 1'b1;
`ifdef AN_SEC_UNCORR_EN
            out_uncorr <= !(hit_pos || hit_neg);
`endif
          end
          // + match wins over - match; correction wraps modulo 2^CODE_W.
          if (hit_pos) begin
            out_loc <= loc_mag;
            out_cw  <= cw - bit_i;
          end else if (hit_neg) begin
            out_loc <= -loc_mag;
            out_cw  <= cw + bit_i;
          end else if (cnt_last) begin
            out_loc <= '0;
            out_cw  <= cw;
          end else begin
            p   <= md_y;
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
